uart_rx_arbiter: RTL

Merges the byte streams of NUM_CH uart_receiver instances into one valid/ready byte stream for a single downstream consumer (command parser or bus bridge).
Each channel has its own small FIFO, which absorbs the one-cycle received_byte strobes. A round-robin scheduler then drains the channels into a registered output stage that carries the source channel ID.
Bytes that arrive at a full channel FIFO are dropped, and the drop is flagged per channel.

---
 rtl/uart_rx_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_arbiter.sv
// uart_rx_arbiter: per-channel byte FIFOs drained round-robin into one
// registered valid/ready stream. Define UART_RX_ARB_CNT_EN for byte_cnt.
module uart_rx_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*DATA_W-1:0]   rx_data,
  input  logic [NUM_CH-1:0]          rx_received,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH-1:0]          ovr_flag,
  input  logic [NUM_CH-1:0]          ovr_clr,
`ifdef UART_RX_ARB_CNT_EN
  output logic [NUM_CH*16-1:0]       byte_cnt,
`endif
  output logic [NUM_CH-1:0]          fifo_empty
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t state;

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wptr [NUM_CH];
  logic [PTR_W-1:0]  rptr [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] ovr_set;

  logic              load;
  logic              any_ne;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   rr_last;
  logic [DATA_W-1:0] head;

  assign out_valid = (state == HOLD);
  assign load      = !out_valid || out_ready;
  assign head      = mem[grant][rptr[grant]];

  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]     = (cnt[i] == CNT_W'(DEPTH));
      nonempty[i] = (cnt[i] != '0);
    end
  end

  assign fifo_empty = ~nonempty;

  // Scan rr_last+1 .. rr_last+NUM_CH, wrapping; first non-empty wins.
  always_comb begin
    logic [CH_W:0] sum;
    logic [CH_W-1:0] c;
    grant  = '0;
    any_ne = 1'b0;
    sum    = '0;
    c      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      sum = {1'b0, rr_last} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH))
        sum = sum - (CH_W+1)'(NUM_CH);
      c = sum[CH_W-1:0];
      if (!any_ne && nonempty[c]) begin
        any_ne = 1'b1;
        grant  = c;
      end
    end
  end

  // A pop at the same edge frees the slot, so a full FIFO still accepts.
  always_comb begin
    pop     = '0;
    push    = '0;
    ovr_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i]     = load && any_ne && (grant == CH_W'(i));
      push[i]    = rx_received[i] && (!full[i] || pop[i]);
      ovr_set[i] = rx_received[i] && full[i] && !pop[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (push[i])
        mem[i][wptr[i]] <= rx_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i])
          wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])
          rptr[i] <= rptr[i] + 1'b1;
        if (push[i] && !pop[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (!push[i] && pop[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_ch   <= '0;
      rr_last  <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      if (any_ne) begin
        state    <= HOLD;
        out_data <= head;
        out_ch   <= grant;
        rr_last  <= grant;
      end else begin
        state    <= EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovr_flag <= '0;
    else
      ovr_flag <= (ovr_flag & ~ovr_clr) | ovr_set;
  end

`ifdef UART_RX_ARB_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (push[i])
          byte_cnt[i*16 +: 16] <= byte_cnt[i*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule
